// File: rtl/openhw_ieu_wbarb.sv
// Integer register-file write-port arbiter: the pipeline writeback always wins,
// while the MDU and FPU divide results share the remaining slots round-robin.
module openhw_ieu_wbarb #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PipeValidW,
  input  logic [4:0]      PipeRdW,
  input  logic [XLEN-1:0] PipeResultW,
  input  logic            MDUValid,
  input  logic [4:0]      MDURd,
  input  logic [XLEN-1:0] MDUResult,
  output logic            MDUReady,
  input  logic            FDivValid,
  input  logic [4:0]      FDivRd,
  input  logic [XLEN-1:0] FDivResult,
  output logic            FDivReady,
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ResultW,
  output logic            StarveStallD
);

  typedef enum logic {
    GntMdu  = 1'b0,
    GntFdiv = 1'b1
  } gntSrcT;

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  gntSrcT     lastGnt;
  logic [3:0] waitCnt;
  logic [3:0] waitCntNext;
  logic       pipeReal;
  logic       mduReal;
  logic       fdivReal;
  logic       grantMdu;
  logic       grantFdiv;

  always_comb begin
    pipeReal  = PipeValidW && (PipeRdW != 5'd0);
    mduReal   = MDUValid && (MDURd != 5'd0);
    fdivReal  = FDivValid && (FDivRd != 5'd0);
    grantMdu  = !pipeReal && mduReal && (!fdivReal || (lastGnt == GntFdiv));
    grantFdiv = !pipeReal && fdivReal && (!mduReal || (lastGnt == GntMdu));

    // Null late requests are acknowledged at once without taking a write slot.
    MDUReady  = reset && ((MDUValid && (MDURd == 5'd0)) || grantMdu);
    FDivReady = reset && ((FDivValid && (FDivRd == 5'd0)) || grantFdiv);

    waitCntNext = 4'd0;
    if (!(grantMdu || grantFdiv) && (mduReal || fdivReal)) begin
      waitCntNext = (waitCnt >= StarveLim) ? StarveLim : waitCnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW    <= 1'b0;
      RdW          <= 5'd0;
      ResultW      <= '0;
      StarveStallD <= 1'b0;
      waitCnt      <= 4'd0;
      lastGnt      <= GntFdiv;
    end else begin
      RegWriteW <= pipeReal || grantMdu || grantFdiv;
      if (pipeReal) begin
        RdW     <= PipeRdW;
        ResultW <= PipeResultW;
      end else if (grantMdu) begin
        RdW     <= MDURd;
        ResultW <= MDUResult;
        lastGnt <= GntMdu;
      end else if (grantFdiv) begin
        RdW     <= FDivRd;
        ResultW <= FDivResult;
        lastGnt <= GntFdiv;
      end
      waitCnt      <= waitCntNext;
      StarveStallD <= (waitCntNext == StarveLim);
    end
  end

endmodule

// File: tb/tb_openhw_ieu_wbarb.sv
// Scoreboard bench for openhw_ieu_wbarb: directed cycles push expected writes,
// a negedge monitor pops and compares each register-file write.
module tb_openhw_ieu_wbarb;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            PipeValidW;
  logic [4:0]      PipeRdW;
  logic [XLEN-1:0] PipeResultW;
  logic            MDUValid;
  logic [4:0]      MDURd;
  logic [XLEN-1:0] MDUResult;
  logic            MDUReady;
  logic            FDivValid;
  logic [4:0]      FDivRd;
  logic [XLEN-1:0] FDivResult;
  logic            FDivReady;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            StarveStallD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] res;
  } wrT;
  wrT expQ[$];

  openhw_ieu_wbarb #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .PipeValidW(PipeValidW), .PipeRdW(PipeRdW), .PipeResultW(PipeResultW),
    .MDUValid(MDUValid), .MDURd(MDURd), .MDUResult(MDUResult), .MDUReady(MDUReady),
    .FDivValid(FDivValid), .FDivRd(FDivRd), .FDivResult(FDivResult), .FDivReady(FDivReady),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .StarveStallD(StarveStallD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RegWriteW === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd %0d data %0h expected no write", RdW, ResultW);
      end else begin
        wrT e;
        e = expQ.pop_front();
        chk("write_rd", 64'(RdW), 64'(e.rd));
        chk("write_data", ResultW, e.res);
      end
    end
  end

  // One cycle: drive after the edge, check readies and the stall flag at the negedge.
  task automatic cyc(input logic pv, input logic [4:0] prd, input logic [XLEN-1:0] pres,
                     input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] mres,
                     input logic fv, input logic [4:0] frd, input logic [XLEN-1:0] fres,
                     input logic expM, input logic expF, input logic expStall, input string nm);
    wrT w;
    @(posedge clk);
    #1;
    PipeValidW = pv; PipeRdW = prd; PipeResultW = pres;
    MDUValid = mv; MDURd = mrd; MDUResult = mres;
    FDivValid = fv; FDivRd = frd; FDivResult = fres;
    if (pv && prd != 5'd0) begin
      w.rd = prd; w.res = pres; expQ.push_back(w);
    end else if (expM && mrd != 5'd0) begin
      w.rd = mrd; w.res = mres; expQ.push_back(w);
    end else if (expF && frd != 5'd0) begin
      w.rd = frd; w.res = fres; expQ.push_back(w);
    end
    @(negedge clk);
    chk({nm, "_mdu_ready"}, 64'(MDUReady), 64'(expM));
    chk({nm, "_fdiv_ready"}, 64'(FDivReady), 64'(expF));
    chk({nm, "_stall"}, 64'(StarveStallD), 64'(expStall));
  endtask

  task automatic idle(input logic expStall, input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, expStall, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int mIdx;
    int fIdx;
    logic expM;
    logic [4:0] mrd;
    logic [4:0] frd;

    reset = 1'b0;
    PipeValidW = 1'b0; PipeRdW = '0; PipeResultW = '0;
    MDUValid = 1'b1; MDURd = 5'd3; MDUResult = '0;
    FDivValid = 1'b1; FDivRd = 5'd4; FDivResult = '0;
    repeat (2) @(negedge clk);
    chk("rst_mdu_ready", 64'(MDUReady), 64'd0);
    chk("rst_fdiv_ready", 64'(FDivReady), 64'd0);
    chk("rst_regwrite", 64'(RegWriteW), 64'd0);
    chk("rst_rd", 64'(RdW), 64'd0);
    chk("rst_result", ResultW, 64'd0);
    chk("rst_stall", 64'(StarveStallD), 64'd0);
    MDUValid = 1'b0; FDivValid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Pipeline write
    cyc(1, 5, 64'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0, "pipe");
    idle(0, "idle0");

    // Tie after reset: MDU first, then FDiv
    cyc(0, 0, 0, 1, 3, 64'h33, 1, 4, 64'h44, 1, 0, 0, "tie0");
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 64'h44, 0, 1, 0, "tie1");
    idle(0, "idle1");

    // Starvation: stall visible after the 4th waiting cycle
    for (int i = 0; i < 5; i++)
      cyc(1, 10, 64'h100 + 64'(i), 1, 7, 64'h77, 0, 0, 0, 0, 0, (i == 4), "starve");
    cyc(0, 0, 0, 1, 7, 64'h77, 0, 0, 0, 1, 0, 1, "starve_grant");
    idle(0, "starve_release");

    // Null MDU requests are acked and never counted as waiting
    for (int i = 0; i < 5; i++)
      cyc(1, 9, 64'h90 + 64'(i), 1, 0, 64'hDEAD, 0, 0, 0, 1, 0, 0, "null_mdu");
    idle(0, "null_idle");

    // Null pipeline request leaves the port to a late requester
    cyc(1, 0, 64'hBAD, 0, 0, 0, 1, 12, 64'hC12, 0, 1, 0, "pipe_null");
    idle(0, "idle2");

    // Repeated contention: grants alternate starting with MDU
    mIdx = 0; fIdx = 0;
    for (int i = 0; i < 6; i++) begin
      expM = ((i % 2) == 0);
      mrd = 5'(16 + mIdx);
      frd = 5'(24 + fIdx);
      cyc(0, 0, 0, 1, mrd, 64'h1000 + 64'(mrd), 1, frd, 64'h2000 + 64'(frd),
          expM, !expM, 0, "rr");
      if (expM) mIdx++; else fIdx++;
    end
    idle(0, "idle3");

    // Reset while FDiv waits with three cycles on its counter
    for (int i = 0; i < 3; i++)
      cyc(1, 21, 64'h2100 + 64'(i), 0, 0, 0, 1, 20, 64'h2020, 0, 0, 0, "mid_wait");
    @(posedge clk); #1 PipeValidW = 1'b0;
    @(negedge clk);
    chk("pre_rst_fdiv_ready", 64'(FDivReady), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_fdiv_ready", 64'(FDivReady), 64'd0);
    chk("mid_rst_regwrite", 64'(RegWriteW), 64'd0);
    chk("mid_rst_rd", 64'(RdW), 64'd0);
    chk("mid_rst_result", ResultW, 64'd0);
    chk("mid_rst_stall", 64'(StarveStallD), 64'd0);
    FDivValid = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 1, 20, 64'h2020, 0, 1, 0, "re_present");
    idle(0, "idle4");
    idle(0, "idle5");
    chk("hold_regwrite", 64'(RegWriteW), 64'd0);
    chk("hold_rd", 64'(RdW), 64'd20);
    chk("hold_result", ResultW, 64'h2020);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
